// File: rtl/pool_sequencer.sv
`timescale 1ns/1ps
// Time-shares one 2x2/stride-2 max_pool across NUM_CHANNELS feature maps: streams each
// map out of the conv RAM in raster order and packs pooled results per channel.
module pool_sequencer #(
    parameter int DATA_WIDTH    = 20,
    parameter int INPUT_WIDTH   = 26,
    parameter int INPUT_HEIGHT  = 26,
    parameter int NUM_CHANNELS  = 8,
    parameter int CLEAR_CYCLES  = 2,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int RD_ADDR_WIDTH = 13,
    parameter int WR_ADDR_WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     rd_en,
    output logic [RD_ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     pool_enable,
    output logic [DATA_WIDTH-1:0]    pool_data_in,
    output logic                     pool_valid_in,
    input  logic [DATA_WIDTH-1:0]    pool_data_out,
    input  logic                     pool_valid_out,
    output logic                     wr_en,
    output logic [WR_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data
);

    localparam int P      = INPUT_WIDTH * INPUT_HEIGHT;
    localparam int Q      = (INPUT_WIDTH / 2) * (INPUT_HEIGHT / 2);
    localparam int PIX_W  = (P > 1) ? $clog2(P) : 1;
    localparam int OCNT_W = $clog2(Q + 1);
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CLR_W  = $clog2(CLEAR_CYCLES + 1);
    localparam int DRN_W  = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [PIX_W-1:0]         PIX_LAST  = PIX_W'(P - 1);
    localparam logic [OCNT_W-1:0]        OCNT_FULL = OCNT_W'(Q);
    localparam logic [CH_W-1:0]          CH_LAST   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [CLR_W-1:0]         CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [DRN_W-1:0]         DRN_LAST  = DRN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [RD_ADDR_WIDTH-1:0] RD_STEP   = RD_ADDR_WIDTH'(P);
    localparam logic [WR_ADDR_WIDTH-1:0] WR_STEP   = WR_ADDR_WIDTH'(Q);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                     state_reg, state_next;
    logic [CH_W-1:0]            ch_reg, ch_next;
    logic [PIX_W-1:0]           pix_reg, pix_next;
    logic [OCNT_W-1:0]          ocnt_reg, ocnt_next;
    logic [CLR_W-1:0]           clr_cnt_reg, clr_cnt_next;
    logic [DRN_W-1:0]           drain_cnt_reg, drain_cnt_next;
    logic [RD_ADDR_WIDTH-1:0]   rd_base_reg, rd_base_next;
    logic [WR_ADDR_WIDTH-1:0]   wr_base_reg, wr_base_next;
    logic                       error_reg, error_next;
    logic                       pool_valid_in_reg;
    logic                       wr_en_reg, wr_en_next;
    logic [WR_ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
    logic [DATA_WIDTH-1:0]      wr_data_reg, wr_data_next;
    logic                       out_accept;

    // Pool results only count while a channel is actually being pooled.
    assign out_accept = pool_valid_out &&
                        ((state_reg == S_STREAM) || (state_reg == S_DRAIN));

    always_comb begin
        state_next     = state_reg;
        ch_next        = ch_reg;
        pix_next       = pix_reg;
        ocnt_next      = ocnt_reg;
        clr_cnt_next   = clr_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        rd_base_next   = rd_base_reg;
        wr_base_next   = wr_base_reg;
        error_next     = error_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;

        if (out_accept) begin
            if (ocnt_reg == OCNT_FULL) begin
                error_next = 1'b1;
            end else begin
                wr_en_next   = 1'b1;
                wr_addr_next = wr_base_reg + WR_ADDR_WIDTH'(ocnt_reg);
                wr_data_next = pool_data_out;
                ocnt_next    = ocnt_reg + OCNT_W'(1);
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_CLEAR;
                    ch_next      = '0;
                    rd_base_next = '0;
                    wr_base_next = '0;
                    pix_next     = '0;
                    ocnt_next    = '0;
                    clr_cnt_next = '0;
                    error_next   = 1'b0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = S_STREAM;
                end else begin
                    clr_cnt_next = clr_cnt_reg + CLR_W'(1);
                end
            end
            S_STREAM: begin
                if (pix_reg == PIX_LAST) begin
                    state_next     = S_DRAIN;
                    drain_cnt_next = '0;
                end else begin
                    pix_next = pix_reg + PIX_W'(1);
                end
            end
            S_DRAIN: begin
                if (ocnt_reg == OCNT_FULL) begin
                    state_next = S_NEXT;
                end else if (drain_cnt_reg == DRN_LAST) begin
                    error_next = 1'b1;
                    state_next = S_NEXT;
                end else begin
                    drain_cnt_next = drain_cnt_reg + DRN_W'(1);
                end
            end
            S_NEXT: begin
                if (ch_reg == CH_LAST) begin
                    state_next = S_DONE;
                end else begin
                    state_next   = S_CLEAR;
                    ch_next      = ch_reg + CH_W'(1);
                    rd_base_next = rd_base_reg + RD_STEP;
                    wr_base_next = wr_base_reg + WR_STEP;
                    pix_next     = '0;
                    ocnt_next    = '0;
                    clr_cnt_next = '0;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= S_IDLE;
            ch_reg            <= '0;
            pix_reg           <= '0;
            ocnt_reg          <= '0;
            clr_cnt_reg       <= '0;
            drain_cnt_reg     <= '0;
            rd_base_reg       <= '0;
            wr_base_reg       <= '0;
            error_reg         <= 1'b0;
            pool_valid_in_reg <= 1'b0;
            wr_en_reg         <= 1'b0;
            wr_addr_reg       <= '0;
            wr_data_reg       <= '0;
        end else begin
            state_reg         <= state_next;
            ch_reg            <= ch_next;
            pix_reg           <= pix_next;
            ocnt_reg          <= ocnt_next;
            clr_cnt_reg       <= clr_cnt_next;
            drain_cnt_reg     <= drain_cnt_next;
            rd_base_reg       <= rd_base_next;
            wr_base_reg       <= wr_base_next;
            error_reg         <= error_next;
            pool_valid_in_reg <= rd_en;
            wr_en_reg         <= wr_en_next;
            wr_addr_reg       <= wr_addr_next;
            wr_data_reg       <= wr_data_next;
        end
    end

    // NEXT keeps the pool enabled so only the CLEAR cycles separate channels.
    assign busy          = (state_reg != S_IDLE);
    assign done          = (state_reg == S_DONE);
    assign error         = error_reg;
    assign rd_en         = (state_reg == S_STREAM);
    assign rd_addr       = rd_base_reg + RD_ADDR_WIDTH'(pix_reg);
    assign pool_enable   = (state_reg == S_STREAM) || (state_reg == S_DRAIN) ||
                           (state_reg == S_NEXT);
    assign pool_data_in  = rd_data;
    assign pool_valid_in = pool_valid_in_reg;
    assign wr_en         = wr_en_reg;
    assign wr_addr       = wr_addr_reg;
    assign wr_data       = wr_data_reg;

endmodule

// File: tb/tb_pool_sequencer.sv
`timescale 1ns/1ps
// Bench for pool_sequencer: RAM and max_pool models around the DUT, expected writes
// precomputed from RAM contents into a scoreboard queue.
module tb_pool_sequencer;

    localparam int DW = 20, W = 26, H = 26, NC = 2, CLR = 2, TMO = 64, RAW = 13, WAW = 11;
    localparam int P = W * H;
    localparam int Q = (W / 2) * (H / 2);
    localparam int RUN_CYC = NC * (CLR + P + 3 + 1) + 1;
    localparam int TMO_CYC = NC * (CLR + P + TMO + 1) + 1;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  busy, done, error;
    logic                  rd_en;
    logic [RAW-1:0]        rd_addr;
    logic signed [DW-1:0]  rd_data;
    logic                  pool_enable;
    logic [DW-1:0]         pool_data_in;
    logic                  pool_valid_in;
    logic signed [DW-1:0]  pool_data_out = '0;
    logic                  pool_valid_out = 1'b0;
    logic                  wr_en;
    logic [WAW-1:0]        wr_addr;
    logic [DW-1:0]         wr_data;

    typedef struct {
        logic [WAW-1:0]       addr;
        logic signed [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic signed [DW-1:0] ram [0:NC*P-1];
    logic signed [DW-1:0] line_buf [0:W-1];
    logic signed [DW-1:0] left_px;
    int prow = 0, pcol = 0;
    bit pool_on = 1'b1;
    int checks = 0, errors = 0, done_cnt = 0, low_cnt = 0, rd_idx = 0;

    pool_sequencer #(
        .DATA_WIDTH(DW), .INPUT_WIDTH(W), .INPUT_HEIGHT(H), .NUM_CHANNELS(NC),
        .CLEAR_CYCLES(CLR), .DRAIN_TIMEOUT(TMO), .RD_ADDR_WIDTH(RAW), .WR_ADDR_WIDTH(WAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .pool_enable(pool_enable),
        .pool_data_in(pool_data_in), .pool_valid_in(pool_valid_in),
        .pool_data_out(pool_data_out), .pool_valid_out(pool_valid_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    function automatic logic signed [DW-1:0] max2(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Behavioural max_pool: result registered one cycle after the block's last pixel.
    always @(posedge clk) begin
        pool_valid_out <= 1'b0;
        if (!pool_enable) begin
            prow <= 0;
            pcol <= 0;
        end else if (pool_valid_in) begin
            if (prow % 2 == 0) begin
                line_buf[pcol] <= pool_data_in;
            end else if (pcol % 2 == 0) begin
                left_px <= pool_data_in;
            end else begin
                pool_data_out  <= max2(max2(line_buf[pcol-1], line_buf[pcol]),
                                       max2(left_px, pool_data_in));
                pool_valid_out <= pool_on;
            end
            if (pcol == W - 1) begin
                pcol <= 0;
                prow <= prow + 1;
            end else begin
                pcol <= pcol + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s actual=%0d required=%0d", tag, act, exp);
        end
    endtask

    task automatic fill_ram(input bit neg);
        for (int i = 0; i < NC * P; i++) ram[i] = neg ? DW'(-i) : DW'(i);
    endtask

    task automatic push_expected();
        exp_t e;
        logic signed [DW-1:0] m;
        for (int c = 0; c < NC; c++)
            for (int br = 0; br < H / 2; br++)
                for (int bc = 0; bc < W / 2; bc++) begin
                    m = ram[c*P + (2*br)*W + 2*bc];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            m = max2(m, ram[c*P + (2*br+dr)*W + 2*bc + dc]);
                    e.addr = WAW'(c*Q + br*(W/2) + bc);
                    e.data = m;
                    exp_q.push_back(e);
                end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!busy) begin
                rd_idx = 0;
            end else if (rd_en) begin
                chk("rd_addr", rd_addr, rd_idx);
                rd_idx++;
            end
            if (wr_en) begin
                chk("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", $signed(wr_data), e.data);
                end
            end
            if (done) done_cnt++;
            if (busy && !pool_enable) low_cnt++;
        end
    end

    task automatic run(input string tag, input bit poke, input bit use_pool,
                       input int exp_cyc, input bit exp_err);
        int cyc;
        int done_base;
        int low_base;
        pool_on = use_pool;
        if (use_pool) push_expected();
        done_base = done_cnt;
        low_base  = low_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_err_clr"}, error, 0);
        while (!done && cyc < exp_cyc + 100) begin
            start = poke && (cyc % 97 == 3);
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_error"}, error, exp_err);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_no_restart"}, done, 0);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_done_pulses"}, done_cnt - done_base, 1);
        chk({tag, "_clear_cycles"}, low_cnt - low_base, 2 * NC + 1);
        $display("run %s: cycles=%0d error=%0b checks=%0d errors=%0d",
                 tag, cyc, error, checks, errors);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int done_base;
        rst_n = 1'b0;
        start = 1'b0;
        fill_ram(1'b0);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_pool_enable", pool_enable, 0);
        chk("rst_pool_valid_in", pool_valid_in, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", busy, 0);

        run("ramp", 1'b0, 1'b1, RUN_CYC, 1'b0);

        fill_ram(1'b1);
        run("neg_poke", 1'b1, 1'b1, RUN_CYC, 1'b0);

        fill_ram(1'b0);
        run("timeout", 1'b0, 1'b0, TMO_CYC, 1'b1);
        run("after_timeout", 1'b0, 1'b1, RUN_CYC, 1'b0);

        // Abort a run mid-stream with a short asynchronous reset.
        push_expected();
        done_base = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (300) @(negedge clk);
        chk("mid_stream_rd_en", rd_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rd_en", rd_en, 0);
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_pool_enable", pool_enable, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (20) @(negedge clk);
        chk("abort_idle", busy, 0);
        chk("abort_no_done", done_cnt - done_base, 0);
        chk("abort_error", error, 0);
        $display("run abort: reset mid-stream checks=%0d errors=%0d", checks, errors);

        run("post_reset", 1'b0, 1'b1, RUN_CYC, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
